// File: rtl/shift_registersipo_rx.sv
// shift_registersipo_rx: LSB-first SIPO receiver that rebuilds WIDTH-bit frames after a sync strobe.
// Emits each completed word with a one-cycle valid pulse and a wrapping frame counter.
module shift_registersipo_rx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync,
  input  logic             sin,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, ALIGN, SHIFT} state_t;
  state_t           r_state, w_next;
  logic [BW-1:0]    r_bit_cnt;
  logic [WIDTH-2:0] r_sr;
  logic [WIDTH-1:0] r_data, w_word;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid, r_busy, w_last, w_done;
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  // sync anywhere but IDLE restarts alignment; on the final bit it chains the next frame
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = sync ? ALIGN : IDLE;
      ALIGN:   w_next = sync ? ALIGN : SHIFT;
      SHIFT:   w_next = sync ? ALIGN : (w_last ? IDLE : SHIFT);
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    w_last = (r_bit_cnt == BW'(WIDTH - 1));
    w_done = (r_state == SHIFT) && w_last;
    w_word = {sin, r_sr};
  end
  // r_sr keeps only the upper WIDTH-1 bits; the lowest bit falls out before it is ever used
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt <= '0;
      r_sr      <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_bit_cnt <= (r_state == SHIFT && !sync && !w_last) ? r_bit_cnt + BW'(1) : '0;
      if (r_state == SHIFT) r_sr <= w_word[WIDTH-1:1];
      if (w_done) begin
        r_data <= w_word;
        r_cnt  <= r_cnt + CNT_W'(1);
      end
      r_valid <= w_done;
      r_busy  <= (w_next != IDLE);
    end
  end
  assign data_out  = r_data;
  assign valid     = r_valid;
  assign busy      = r_busy;
  assign frame_cnt = r_cnt;
endmodule

// File: tb/tb_shift_registersipo_rx.sv
// tb_shift_registersipo_rx: directed and table-driven checks of the SIPO receiver against a
// bench-side serializer that drives sync/sin like the PISO transmitter.
module tb_shift_registersipo_rx;
  logic       clk = 1'b0, rst = 1'b0, sync = 1'b0, sin = 1'b0;
  logic [7:0] data_out, frame_cnt;
  logic       valid, busy;
  int         n_vec = 0, n_bad = 0;
  logic [7:0] exp_cnt = '0;
  logic [7:0] held;

  typedef struct { logic [7:0] word; logic [7:0] cnt; } vec_t;
  vec_t vecs[5];

  shift_registersipo_rx #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .sync(sync), .sin(sin),
    .data_out(data_out), .valid(valid), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; sync = 1'b0; sin = 1'b0;
    step(); step();
    rst = 1'b0;
    exp_cnt = '0;
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", data_out, 0);
    chk("rst_cnt", frame_cnt, 0);
  endtask

  // edge e: sync sampled
  task automatic start();
    sync = 1'b1; sin = 1'b0;
    step();
    sync = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_valid", valid, 0);
  endtask

  // edges e+1 .. e+9; optional sync on the final-bit edge chains the next frame
  task automatic body(input logic [7:0] w, input bit sync_last);
    sin = 1'b0;
    step();
    chk("align_valid", valid, 0);
    for (int k = 0; k < 8; k++) begin
      sin  = w[k];
      sync = (k == 7) && sync_last;
      step();
      if (k < 7) begin
        chk("mid_valid", valid, 0);
        chk("mid_busy", busy, 1);
      end
    end
    sync = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    chk("done_valid", valid, 1);
    chk("done_data", data_out, w);
    chk("done_cnt", frame_cnt, exp_cnt);
    chk("done_busy", busy, sync_last);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 8'd1};
    vecs[1] = '{8'h00, 8'd2};
    vecs[2] = '{8'hFF, 8'd3};
    vecs[3] = '{8'h5A, 8'd4};
    vecs[4] = '{8'h81, 8'd5};

    do_reset();
    for (int i = 0; i < 5; i++) begin
      start();
      body(vecs[i].word, 1'b0);
      chk("tbl_cnt", frame_cnt, vecs[i].cnt);
      step();
      chk("tbl_pulse_end", valid, 0);
      chk("tbl_idle", busy, 0);
    end

    // back-to-back frames with sync on the final-bit edge
    do_reset();
    start();
    body(8'h3C, 1'b1);
    body(8'hC3, 1'b0);
    chk("b2b_cnt", frame_cnt, 2);
    step();
    chk("b2b_pulse_end", valid, 0);

    // abort: sync again at e+4
    do_reset();
    start();
    sin = 1'b0; step();
    for (int k = 0; k < 2; k++) begin
      sin = 1'b0; step();
      chk("abort_valid", valid, 0);
    end
    start();
    chk("abort_cnt", frame_cnt, 0);
    chk("abort_data", data_out, 0);
    body(8'h81, 1'b0);
    chk("abort_final_cnt", frame_cnt, 1);

    // reset mid-frame at e+5
    do_reset();
    start();
    body(8'h11, 1'b0);
    start();
    sin = 1'b0; step();
    for (int k = 0; k < 3; k++) begin
      sin = k[0] ? 1'b1 : 1'b0;
      step();
    end
    rst = 1'b1; step(); rst = 1'b0;
    exp_cnt = '0;
    chk("midrst_data", data_out, 0);
    chk("midrst_cnt", frame_cnt, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", valid, 0);
    start();
    body(8'hFF, 1'b0);
    chk("midrst_final_cnt", frame_cnt, 1);

    // sin activity without sync
    step();
    held = data_out;
    for (int k = 0; k < 20; k++) begin
      sin = ~sin;
      step();
      chk("idle_valid", valid, 0);
      chk("idle_busy", busy, 0);
    end
    chk("idle_data", data_out, held);
    chk("idle_cnt", frame_cnt, 1);

    // 256 random frames, counter wraps to zero
    do_reset();
    start();
    for (int i = 0; i < 256; i++) begin
      body(8'($urandom_range(0, 255)), i != 255);
      if (i == 254) chk("wrap_pre", frame_cnt, 255);
    end
    chk("wrap_cnt", frame_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
